// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register outstanding-write tracker for the 15-entry
// Y86-64 register file. Counts writes posted by destE/destM at issue and
// retired at writeback, flags RAW hazards on srcA/srcB, and stalls issue when
// a counter would saturate.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- when defined, a source whose
// last pending write retires this cycle is not reported busy, because the
// register file forwards the write to the same-cycle read.
module regfile_scoreboard #(
    parameter int                    ADDR_WID = 4,
    parameter int                    NREG     = 15,
    parameter logic [ADDR_WID-1:0]   NONREG   = 4'hF,
    parameter int                    CNT_WID  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic                wbE_valid,
    input  logic [ADDR_WID-1:0] wbE_addr,
    input  logic                wbM_valid,
    input  logic [ADDR_WID-1:0] wbM_addr,
    output logic                busyA,
    output logic                busyB,
    output logic [NREG-1:0]     pending,
    output logic                err
);

    localparam int CNT_MAX = (1 << CNT_WID) - 1;
    // Wide enough to hold cnt + 2 and cnt - 2 without wrapping.
    localparam int SUM_WID = CNT_WID + 3;
    localparam int SAT_WID = CNT_WID + 2;

    logic [CNT_WID-1:0] cnt_q [NREG];
    logic [CNT_WID-1:0] cnt_d [NREG];
    logic               err_q;
    logic [NREG-1:0]    underflow;
    logic [1:0]         inc [NREG];
    logic [1:0]         dec [NREG];
    logic               accept;

    logic [CNT_WID-1:0] cnt_a, cnt_b, cnt_e, cnt_m;
    logic [1:0]         dec_a, dec_b;
    logic               busy_a_raw, busy_b_raw, sat;

    assign accept = issue_valid & issue_ready;

    // Per-register increment/decrement and next-count arithmetic.
    // Register indices are 0..NREG-1, so the NONREG code never matches.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [SUM_WID-1:0] sum;

            assign inc[gi] = 2'(accept && (destE == ADDR_WID'(gi)))
                           + 2'(accept && (destM == ADDR_WID'(gi)));
            assign dec[gi] = 2'(wbE_valid && (wbE_addr == ADDR_WID'(gi)))
                           + 2'(wbM_valid && (wbM_addr == ADDR_WID'(gi)));

            assign sum = SUM_WID'(cnt_q[gi]) + SUM_WID'(inc[gi]) - SUM_WID'(dec[gi]);

            // A negative result means a writeback with nothing outstanding:
            // clamp to zero and report it.
            assign underflow[gi] = sum[SUM_WID-1];
            assign cnt_d[gi]     = sum[SUM_WID-1] ? '0 : sum[CNT_WID-1:0];
            assign pending[gi]   = (cnt_q[gi] != '0);
        end
    endgenerate

    // Look up the counts addressed by the source and destination selects.
    always_comb begin
        cnt_a = '0;
        cnt_b = '0;
        cnt_e = '0;
        cnt_m = '0;
        dec_a = '0;
        dec_b = '0;
        for (int r = 0; r < NREG; r++) begin
            if (srcA == ADDR_WID'(r)) begin
                cnt_a = cnt_q[r];
                dec_a = dec[r];
            end
            if (srcB == ADDR_WID'(r)) begin
                cnt_b = cnt_q[r];
                dec_b = dec[r];
            end
            if (destE == ADDR_WID'(r)) cnt_e = cnt_q[r];
            if (destM == ADDR_WID'(r)) cnt_m = cnt_q[r];
        end
    end

    // Hazard and saturation decode; same-cycle writebacks do not relieve saturation.
    always_comb begin
        busy_a_raw = (srcA != NONREG) && (cnt_a != '0);
        busy_b_raw = (srcB != NONREG) && (cnt_b != '0);
`ifdef SCOREBOARD_BYPASS_EN
        if (SUM_WID'(cnt_a) == SUM_WID'(dec_a)) busy_a_raw = 1'b0;
        if (SUM_WID'(cnt_b) == SUM_WID'(dec_b)) busy_b_raw = 1'b0;
`endif
        if ((destE == destM) && (destE != NONREG)) begin
            // popq %rsp style double write to one register
            sat = (SAT_WID'(cnt_e) + SAT_WID'(2)) > SAT_WID'(CNT_MAX);
        end else begin
            sat = ((destE != NONREG) && (SAT_WID'(cnt_e) + SAT_WID'(1) > SAT_WID'(CNT_MAX)))
               || ((destM != NONREG) && (SAT_WID'(cnt_m) + SAT_WID'(1) > SAT_WID'(CNT_MAX)));
        end
    end

    // Outputs are forced quiet while reset is held.
    assign busyA       = ~RST & busy_a_raw;
    assign busyB       = ~RST & busy_b_raw;
    assign issue_ready = ~RST & ~busy_a_raw & ~busy_b_raw & ~sat;
    assign err         = err_q;

    // Counter and sticky error state; reset discards all outstanding tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            if (|underflow) err_q <= 1'b1;
        end
    end

endmodule
